onehot_rr_arb: RTL

ONEHOT_RR_ARB -- requirements
Module: onehot_rr_arb

---
 rtl/onehot_rr_arb_if.sv | 23 ++
 rtl/onehot_rr_arb.sv | 116 +++++++++++
 2 files changed

// File: rtl/onehot_rr_arb_if.sv
// Handshake bundle between the requesters and the one-hot round-robin arbiter.
interface onehot_rr_arb_if #(
  parameter int WORDCOUNT = 4,
  parameter int IDXW      = 2
);
  logic [WORDCOUNT-1:0] req;
  logic [WORDCOUNT-1:0] last;
  logic                 rdy;
  logic [WORDCOUNT-1:0] grant;
  logic [IDXW-1:0]      gidx;
  logic                 vld;
  logic                 eob;

  modport master (
    output req, last, rdy,
    input  grant, gidx, vld, eob
  );

  modport slave (
    input  req, last, rdy,
    output grant, gidx, vld, eob
  );
endinterface

// File: rtl/onehot_rr_arb.sv
// Burst-level round-robin arbiter with a registered one-hot grant that drives
// a downstream word mux select directly. A grant is held for a whole burst and
// only moves on the accepted beat that carries last.
//
// state | meaning
// IDLE  | no grant; next requester found by scanning from ptr
// BUSY  | one requester owns the mux until its eob
module onehot_rr_arb #(
  parameter int WORDCOUNT = 4,
  parameter int IDXW      = 2
) (
  input logic              c,
  input logic              r,
  onehot_rr_arb_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [WORDCOUNT-1:0] grant_q, grant_d;
  logic [IDXW-1:0]      gidx_q, gidx_d;
  logic [IDXW-1:0]      ptr_q, ptr_d;

  logic [IDXW-1:0]      ptr_nxt;
  logic [IDXW-1:0]      scan_start;
  logic [WORDCOUNT-1:0] scan_cand;
  logic [IDXW:0]        pick_res;
  logic                 vld;
  logic                 eob;

  // First set bit of cand scanning start, start+1, ... with wrap at WORDCOUNT.
  // Returns {found, index}. Scanning downwards lets the smallest offset win.
  function automatic logic [IDXW:0] pick(input logic [WORDCOUNT-1:0] cand,
                                         input logic [IDXW-1:0]      start);
    logic [IDXW:0] res;
    int            j;
    res = '0;
    for (int i = WORDCOUNT - 1; i >= 0; i--) begin
      j = int'(start) + i;
      if (j >= WORDCOUNT) j = j - WORDCOUNT;
      if (cand[j]) res = {1'b1, IDXW'(j)};
    end
    return res;
  endfunction

  // State, grant, index and priority pointer registers.
  always_ff @(posedge c) begin
    if (r) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: pick a winner from IDLE, or hand over on eob with the finisher masked.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    // Explicit wrap keeps ptr below WORDCOUNT when it is not a power of two.
    ptr_nxt    = (gidx_q == IDXW'(WORDCOUNT - 1)) ? '0 : gidx_q + 1'b1;
    scan_start = ptr_q;
    scan_cand  = bus.req;
    if (state_q == BUSY) begin
      scan_start = ptr_nxt;
      scan_cand  = bus.req & ~grant_q;
    end
    pick_res = pick(scan_cand, scan_start);
    case (state_q)
      IDLE: begin
        if (pick_res[IDXW]) begin
          state_d = BUSY;
          grant_d = {{(WORDCOUNT-1){1'b0}}, 1'b1} << pick_res[IDXW-1:0];
          gidx_d  = pick_res[IDXW-1:0];
        end
      end
      BUSY: begin
        if (eob) begin
          ptr_d = ptr_nxt;
          if (pick_res[IDXW]) begin
            grant_d = {{(WORDCOUNT-1){1'b0}}, 1'b1} << pick_res[IDXW-1:0];
            gidx_d  = pick_res[IDXW-1:0];
          end else begin
            state_d = IDLE;
            grant_d = '0;
            gidx_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        gidx_d  = '0;
      end
    endcase
  end

  // Outputs: beat valid and end-of-burst qualified by the current grant.
  always_comb begin
    vld = |(grant_q & bus.req);
    eob = vld & bus.rdy & |(grant_q & bus.last);
  end

  assign bus.grant = grant_q;
  assign bus.gidx  = gidx_q;
  assign bus.vld   = vld;
  assign bus.eob   = eob;

endmodule
